seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_pkg.sv | 19 +
 rtl/hex_to_seg7.sv | 14 +
 rtl/seg_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants for the two-digit seven-segment scan driver
// Contents: scan FSM state encoding, 16-entry hex segment table, blank pattern.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg_scan_pkg;

    localparam logic [1:0] ST_SHOW_LO  = 2'd0;
    localparam logic [1:0] ST_BLANK_LO = 2'd1;
    localparam logic [1:0] ST_SHOW_HI  = 2'd2;
    localparam logic [1:0] ST_BLANK_HI = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index 0 is the rightmost element of the concatenation.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to seven-segment pattern decoder
// Ports:
//   nibble  in  4  hex digit 0..F
//   seg     out 7  segment pattern {g,f,e,d,c,b,a}, active-high
module hex_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - two-digit multiplexed seven-segment scan driver with wrap indicator
// Ports:
//   clk       in  1  single clock, rising edge
//   reset     in  1  asynchronous, active-high reset
//   value     in  8  count value from the upstream counter
//   load      in  1  capture strobe for value
//   hold      in  1  blocks capture while high; refresh keeps running
//   seg       out 7  segments {g,f,e,d,c,b,a}, active-high
//   dp        out 1  decimal point, lit on the high digit when the shown value wrapped
//   digit_en  out 2  one-hot digit enable; bit0 = low nibble, bit1 = high nibble
//   frame     out 1  one-cycle pulse on the first cycle of each scan frame
// Optional feature: define SEG_SCAN_LZ_BLANK_EN for leading-zero blanking of the high digit.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int DIV_W        = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       load,
    input  logic       hold,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_en,
    output logic       frame
);

    localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYCLES - 1);

    logic [1:0]       state;
    logic [DIV_W-1:0] presc;
    logic [3:0]       blank_cnt;
    logic [7:0]       shadow;
    logic [7:0]       disp;
    logic             wrap_pending;
    logic             disp_wrap;

    logic             presc_done;
    logic             blank_done;
    logic             frame_edge;
    logic             capture;
    logic             cap_wraps;
    logic [3:0]       nibble;
    logic [6:0]       nibble_seg;
    logic             hi_suppress;

    assign presc_done = &presc;
    assign blank_done = (blank_cnt == BLANK_LAST);
    // The only point where the displayed value may change, so a frame never tears.
    assign frame_edge = (state == ST_BLANK_HI) && blank_done;
    assign capture    = load && !hold;
    assign cap_wraps  = capture && (value < shadow);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_BLANK_HI;
            presc     <= '0;
            blank_cnt <= '0;
        end else begin
            case (state)
                ST_SHOW_LO, ST_SHOW_HI: begin
                    if (presc_done) begin
                        presc <= '0;
                        state <= (state == ST_SHOW_LO) ? ST_BLANK_LO : ST_BLANK_HI;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: begin
                    if (blank_done) begin
                        blank_cnt <= '0;
                        state     <= (state == ST_BLANK_LO) ? ST_SHOW_HI : ST_SHOW_LO;
                    end else begin
                        blank_cnt <= blank_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow       <= '0;
            disp         <= '0;
            wrap_pending <= 1'b0;
            disp_wrap    <= 1'b0;
        end else begin
            if (capture) begin
                shadow <= value;
            end
            // disp takes the pre-edge shadow; a capture on this same edge
            // lands in shadow and is shown one frame later.
            if (frame_edge) begin
                disp         <= shadow;
                disp_wrap    <= wrap_pending;
                wrap_pending <= cap_wraps;
            end else if (cap_wraps) begin
                wrap_pending <= 1'b1;
            end
        end
    end

    assign nibble = (state == ST_SHOW_HI) ? disp[7:4] : disp[3:0];

    hex_to_seg7 u_hex (
        .nibble (nibble),
        .seg    (nibble_seg)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    // A wrapped value keeps its high digit so the dp indicator stays visible.
    assign hi_suppress = (disp[7:4] == 4'd0) && !disp_wrap;
`else
    assign hi_suppress = 1'b0;
`endif

    always_comb begin
        seg      = SEG_BLANK;
        dp       = 1'b0;
        digit_en = 2'b00;
        case (state)
            ST_SHOW_LO: begin
                seg      = nibble_seg;
                digit_en = 2'b01;
            end
            ST_SHOW_HI: begin
                if (!hi_suppress) begin
                    seg      = nibble_seg;
                    dp       = disp_wrap;
                    digit_en = 2'b10;
                end
            end
            default: begin
                seg      = SEG_BLANK;
            end
        endcase
    end

    assign frame = (state == ST_SHOW_LO) && (presc == '0);

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver (DIV_W=2, BLANK_CYCLES=1)
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic       load;
    logic       hold;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_en;
    logic       frame;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] disp;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];

    seg_scan_driver #(
        .DIV_W        (2),
        .BLANK_CYCLES (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .hold     (hold),
        .seg      (seg),
        .dp       (dp),
        .digit_en (digit_en),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic push(input logic [7:0] d, input logic w);
        exp_t e;
        e.disp = d;
        e.wrap = w;
        exp_q.push_back(e);
    endtask

    // Observes one 10-cycle frame on negedges, comparing against the next
    // scoreboard entry. Loads (if any) are driven at the given frame cycles.
    task automatic watch_frame(input int ld_a, input logic [7:0] va,
                               input int ld_b, input logic [7:0] vb,
                               input bit chained);
        exp_t       e;
        int         w;
        logic [1:0] x_en;
        logic [6:0] x_seg;
        logic       x_dp;
        logic       hi_blank;
        bit         drive;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        drive = (ld_a >= 0) || (ld_b >= 0);
        w = 0;
        while (frame !== 1'b1 && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (w >= 30) begin
            check("frame_timeout", 32'd0, 32'd1);
            return;
        end
        if (chained) check("frame_gap", w, 0);
`ifdef SEG_SCAN_LZ_BLANK_EN
        hi_blank = (e.disp[7:4] == 4'd0) && !e.wrap;
`else
        hi_blank = 1'b0;
`endif
        for (int c = 0; c < 10; c++) begin
            x_en  = 2'b00;
            x_seg = 7'h00;
            x_dp  = 1'b0;
            if (c < 4) begin
                x_en  = 2'b01;
                x_seg = hex7(e.disp[3:0]);
            end else if (c >= 5 && c < 9 && !hi_blank) begin
                x_en  = 2'b10;
                x_seg = hex7(e.disp[7:4]);
                x_dp  = e.wrap;
            end
            check($sformatf("en d%02h c%0d", e.disp, c), digit_en, x_en);
            check($sformatf("seg d%02h c%0d", e.disp, c), seg, x_seg);
            check($sformatf("dp d%02h c%0d", e.disp, c), dp, x_dp);
            check($sformatf("frame d%02h c%0d", e.disp, c), frame, (c == 0));
            if (drive) begin
                load = (c == ld_a) || (c == ld_b);
                if (c == ld_a) value = va;
                else if (c == ld_b) value = vb;
            end
            @(negedge clk);
        end
        if (drive) load = 1'b0;
    endtask

    task automatic release_and_check_latency();
        int w;
        reset = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (frame !== 1'b1 && w < 30);
        check("first_frame_latency", w, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        value = 8'h00;
        load  = 1'b0;
        hold  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg", seg, 7'h00);
        check("rst_dp", dp, 1'b0);
        check("rst_en", digit_en, 2'b00);
        check("rst_frame", frame, 1'b0);

        // Idle refresh, display 00
        release_and_check_latency();
        push(8'h00, 1'b0);
        push(8'h00, 1'b0);
        watch_frame(-1, 8'h00, -1, 8'h00, 1'b0);
        watch_frame(-1, 8'h00, -1, 8'h00, 1'b1);

        // Mid-frame load is shown only from the next frame
        push(8'h00, 1'b0);
        push(8'h3A, 1'b0);
        watch_frame(3, 8'h3A, -1, 8'h00, 1'b1);
        watch_frame(-1, 8'h00, -1, 8'h00, 1'b1);

        // FF then 02 in one frame: wrap flagged for exactly one frame
        push(8'h3A, 1'b0);
        push(8'h02, 1'b1);
        push(8'h02, 1'b0);
        watch_frame(1, 8'hFF, 3, 8'h02, 1'b1);
        watch_frame(-1, 8'h00, -1, 8'h00, 1'b1);
        watch_frame(-1, 8'h00, -1, 8'h00, 1'b1);

        // hold blocks capture across three frames, refresh continues
        hold  = 1'b1;
        load  = 1'b1;
        value = 8'h55;
        for (int i = 0; i < 3; i++) begin
            push(8'h02, 1'b0);
            watch_frame(-1, 8'h00, -1, 8'h00, 1'b1);
        end
        hold = 1'b0;
        load = 1'b0;
        push(8'h02, 1'b0);
        watch_frame(-1, 8'h00, -1, 8'h00, 1'b1);

        // Loads on the frame edge: shown a frame later, wrap kept pending
        push(8'h02, 1'b0);
        push(8'h02, 1'b0);
        push(8'h10, 1'b0);
        push(8'h05, 1'b1);
        push(8'h05, 1'b0);
        watch_frame(9, 8'h10, -1, 8'h00, 1'b1);
        watch_frame(9, 8'h05, -1, 8'h00, 1'b1);
        watch_frame(-1, 8'h00, -1, 8'h00, 1'b1);
        watch_frame(-1, 8'h00, -1, 8'h00, 1'b1);
        watch_frame(-1, 8'h00, -1, 8'h00, 1'b1);

        // Leading-zero candidates 07 and 17
        push(8'h05, 1'b0);
        push(8'h07, 1'b0);
        push(8'h17, 1'b0);
        watch_frame(2, 8'h07, -1, 8'h00, 1'b1);
        watch_frame(2, 8'h17, -1, 8'h00, 1'b1);
        watch_frame(-1, 8'h00, -1, 8'h00, 1'b1);

        // Asynchronous reset in the middle of SHOW_HI
        repeat (6) @(negedge clk);
        check("pre_rst_en", digit_en, 2'b10);
        check("pre_rst_seg", seg, 7'h06);
        reset = 1'b1;
        #1;
        check("async_rst_seg", seg, 7'h00);
        check("async_rst_dp", dp, 1'b0);
        check("async_rst_en", digit_en, 2'b00);
        check("async_rst_frame", frame, 1'b0);
        @(negedge clk);
        release_and_check_latency();
        push(8'h00, 1'b0);
        watch_frame(-1, 8'h00, -1, 8'h00, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
